estimator_sample_sequencer: RTL and testbench

- Synthesizable multi-channel sample sequencer for the estimator system (current-, voltage- and further estimator channels).
- Pulls one NCH-wide sample from an upstream source, presents it to the estimator, waits for all per-channel done flags or a timeout, and captures the results.
- Emits captured results on a valid/ready output; replaces the fixed 1500-cycle hold/acknowledge pacing with done-driven early capture and timeout accounting.

---
 rtl/estimator_sample_sequencer_if.sv | 39 +++
 rtl/estimator_sample_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_estimator_sample_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/estimator_sample_sequencer_if.sv
// Handshake and bus bundle between the sample sequencer and its environment
// (run control, upstream sample source, estimator channels, result sink).
interface estimator_sample_sequencer_if #(
   parameter int P   = 32,
   parameter int NCH = 2,
   parameter int AW  = 10
);
   logic               START;
   logic [AW:0]        NUM_SAMPLES;
   logic [NCH*P-1:0]   SMP_DATA;
   logic               SMP_VALID;
   logic               SMP_READY;
   logic [NCH*P-1:0]   EST_IN;
   logic [NCH-1:0]     EST_ACK;
   logic [NCH-1:0]     EST_DONE;
   logic [NCH*P-1:0]   EST_RES;
   logic [NCH*P-1:0]   RES_DATA;
   logic [NCH-1:0]     RES_FLAGS;
   logic               RES_VALID;
   logic               RES_READY;
   logic               BUSY;
   logic [AW:0]        SMP_CNT;
   logic [AW:0]        TIMEOUT_CNT;
   logic               RUN_DONE;

   // master: the sequencer itself
   modport master (
      input  START, NUM_SAMPLES, SMP_DATA, SMP_VALID, EST_DONE, EST_RES, RES_READY,
      output SMP_READY, EST_IN, EST_ACK, RES_DATA, RES_FLAGS, RES_VALID,
             BUSY, SMP_CNT, TIMEOUT_CNT, RUN_DONE
   );

   // slave: run control, sample source, estimator and result sink
   modport slave (
      output START, NUM_SAMPLES, SMP_DATA, SMP_VALID, EST_DONE, EST_RES, RES_READY,
      input  SMP_READY, EST_IN, EST_ACK, RES_DATA, RES_FLAGS, RES_VALID,
             BUSY, SMP_CNT, TIMEOUT_CNT, RUN_DONE
   );
endinterface

// File: rtl/estimator_sample_sequencer.sv
// Multi-channel estimator sample sequencer: fetch, hold until all done edges or timeout, capture, emit.
// Optional macro ESTSEQ_FIXED_HOLD_EN: every sample is held exactly HOLD cycles regardless of done edges.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for START, counters hold last run's values
// S_FETCH   | SMP_READY high, waiting for an upstream sample
// S_WAIT    | sample held on EST_IN, collecting done edges, hold counter running
// S_CAPTURE | results and flags registered, EST_ACK raised
// S_OUT     | RES_VALID held until RES_READY
// S_FINISH  | one-cycle RUN_DONE pulse
module estimator_sample_sequencer #(
   parameter int P    = 32,
   parameter int NCH  = 2,
   parameter int AW   = 10,
   parameter int HOLD = 1500,
   parameter int CW   = 11
) (
   input  logic                                CLK,
   input  logic                                RST,
   estimator_sample_sequencer_if.master        bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_CAPTURE,
      S_OUT,
      S_FINISH
   } state_t;

   localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD - 1);
   localparam logic [NCH-1:0] ALL_ONES  = {NCH{1'b1}};
   localparam logic [AW:0]    CNT_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [CW-1:0]  HOLD_ONE  = {{(CW-1){1'b0}}, 1'b1};

   state_t             r_state;
   state_t             w_state_nxt;

   logic [AW:0]        r_num;
   logic [AW:0]        r_smp_cnt;
   logic [AW:0]        r_to_cnt;
   logic [NCH*P-1:0]   r_est_in;
   logic [NCH-1:0]     r_est_ack;
   logic [NCH-1:0]     r_sticky;
   logic [NCH-1:0]     r_done_prev;
   logic [CW-1:0]      r_hold_cnt;
   logic [NCH*P-1:0]   r_res_data;
   logic [NCH-1:0]     r_res_flags;
   logic               r_res_valid;

   logic [NCH-1:0]     w_edge;
   logic [NCH-1:0]     w_mask;
   logic               w_all_done;
   logic               w_hold_end;
   logic [AW:0]        w_cnt_inc;
   logic               w_smp_ready;
   logic               w_run_done;
`ifndef ESTSEQ_FIXED_HOLD_EN
   logic               w_timeout;
`endif

   // Edges arriving in the same cycle count toward the mask immediately.
   assign w_edge     = bus.EST_DONE & ~r_done_prev;
   assign w_mask     = r_sticky | w_edge;
   assign w_all_done = (w_mask == ALL_ONES);
   assign w_hold_end = (r_hold_cnt == HOLD_LAST);
   assign w_cnt_inc  = r_smp_cnt + CNT_ONE;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_smp_ready = 1'b0;
      w_run_done  = 1'b0;
`ifndef ESTSEQ_FIXED_HOLD_EN
      w_timeout   = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (bus.START) begin
               w_state_nxt = (bus.NUM_SAMPLES == '0) ? S_FINISH : S_FETCH;
            end
         end
         S_FETCH: begin
            w_smp_ready = 1'b1;
            if (bus.SMP_VALID) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
`ifdef ESTSEQ_FIXED_HOLD_EN
            if (w_hold_end) begin
               w_state_nxt = S_CAPTURE;
            end
`else
            // Completion wins over timeout when both land in the same cycle.
            if (w_all_done || w_hold_end) begin
               w_state_nxt = S_CAPTURE;
               w_timeout   = !w_all_done;
            end
`endif
         end
         S_CAPTURE: begin
            w_state_nxt = S_OUT;
         end
         S_OUT: begin
            if (bus.RES_READY) begin
               w_state_nxt = (w_cnt_inc == r_num) ? S_FINISH : S_FETCH;
            end
         end
         S_FINISH: begin
            w_run_done  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_num       <= '0;
         r_smp_cnt   <= '0;
         r_to_cnt    <= '0;
         r_est_in    <= '0;
         r_est_ack   <= '0;
         r_sticky    <= '0;
         r_done_prev <= '0;
         r_hold_cnt  <= '0;
         r_res_data  <= '0;
         r_res_flags <= '0;
         r_res_valid <= 1'b0;
      end else begin
         r_done_prev <= bus.EST_DONE;
         case (r_state)
            S_IDLE: begin
               if (bus.START) begin
                  r_num     <= bus.NUM_SAMPLES;
                  r_smp_cnt <= '0;
                  r_to_cnt  <= '0;
               end
            end
            S_FETCH: begin
               if (bus.SMP_VALID) begin
                  r_est_in   <= bus.SMP_DATA;
                  r_est_ack  <= '0;
                  r_sticky   <= '0;
                  r_hold_cnt <= '0;
               end
            end
            S_WAIT: begin
               r_hold_cnt <= r_hold_cnt + HOLD_ONE;
               r_sticky   <= w_mask;
`ifndef ESTSEQ_FIXED_HOLD_EN
               if (w_timeout) begin
                  r_to_cnt <= r_to_cnt + CNT_ONE;
               end
`endif
            end
            S_CAPTURE: begin
               r_res_data  <= bus.EST_RES;
               r_res_flags <= w_mask;
               r_res_valid <= 1'b1;
               r_est_ack   <= ALL_ONES;
`ifdef ESTSEQ_FIXED_HOLD_EN
               if (!w_all_done) begin
                  r_to_cnt <= r_to_cnt + CNT_ONE;
               end
`endif
            end
            S_OUT: begin
               if (bus.RES_READY) begin
                  r_res_valid <= 1'b0;
                  r_smp_cnt   <= w_cnt_inc;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.SMP_READY   = w_smp_ready;
   assign bus.EST_IN      = r_est_in;
   assign bus.EST_ACK     = r_est_ack;
   assign bus.RES_DATA    = r_res_data;
   assign bus.RES_FLAGS   = r_res_flags;
   assign bus.RES_VALID   = r_res_valid;
   assign bus.BUSY        = (r_state != S_IDLE);
   assign bus.SMP_CNT     = r_smp_cnt;
   assign bus.TIMEOUT_CNT = r_to_cnt;
   assign bus.RUN_DONE    = w_run_done;

endmodule

// File: tb/tb_estimator_sample_sequencer.sv
// Scoreboard bench for estimator_sample_sequencer: directed samples, model estimator adds per-channel offsets.
module tb_estimator_sample_sequencer;
   localparam int P    = 32;
   localparam int NCH  = 2;
   localparam int AW   = 10;
   localparam int HOLD = 1500;
   localparam int CW   = 11;
   localparam int LAT_TO = HOLD + 1;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   estimator_sample_sequencer_if #(.P(P), .NCH(NCH), .AW(AW)) bus ();

   estimator_sample_sequencer #(.P(P), .NCH(NCH), .AW(AW), .HOLD(HOLD), .CW(CW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Estimator model: channel 1 adds 0x100, channel 0 adds 1.
   assign bus.EST_RES = {bus.EST_IN[63:32] + 32'h100, bus.EST_IN[31:0] + 32'h1};

   typedef struct {
      logic [63:0] data;
      logic [1:0]  flags;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int run_done_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   initial forever begin
      @(negedge CLK);
      if (bus.RUN_DONE === 1'b1) run_done_cnt++;
   end

   // Monitor: latency measured at RES_VALID rise, contents compared at handshake.
   initial begin : monitor
      logic vld_q;
      int   rise_cyc;
      exp_t e;
      vld_q = 1'b0;
      rise_cyc = 0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            vld_q = 1'b0;
         end else begin
            if (bus.RES_VALID && !vld_q) rise_cyc = cyc;
            vld_q = bus.RES_VALID;
            if (bus.RES_VALID && bus.RES_READY) begin
               if (sb.size() == 0) begin
                  chk("sb_unexpected", 64'(bus.RES_VALID), 64'd0);
               end else begin
                  e = sb.pop_front();
                  chk("sb_data", bus.RES_DATA, e.data);
                  chk("sb_flags", 64'(bus.RES_FLAGS), 64'(e.flags));
                  chk("sb_latency", 64'(rise_cyc - e.acc), 64'(e.lat));
               end
            end
         end
      end
   end

   task automatic start_run(input int n);
      bus.NUM_SAMPLES = (AW+1)'(n);
      bus.START = 1'b1;
      @(posedge CLK); #1;
      bus.START = 1'b0;
   endtask

   task automatic do_sample(input logic [63:0] data, input logic [63:0] exp_res,
                            input logic [1:0] mask, input int delay, input bit stale,
                            input logic [1:0] exp_flags, input int exp_lat);
      int   n;
      exp_t e;
      n = 0;
      while (!bus.SMP_READY && n < 5000) begin
         @(posedge CLK); #1;
         n++;
      end
      if (!bus.SMP_READY) begin
         chk("smp_ready_wait", 64'(bus.SMP_READY), 64'd1);
         return;
      end
      bus.EST_DONE  = stale ? 2'b11 : 2'b00;
      bus.SMP_DATA  = data;
      bus.SMP_VALID = 1'b1;
      e.data  = exp_res;
      e.flags = exp_flags;
      e.lat   = exp_lat;
      e.acc   = cyc + 1;
      sb.push_back(e);
      @(posedge CLK); #1;
      bus.SMP_VALID = 1'b0;
      chk("est_in", bus.EST_IN, data);
      chk("ack_clear", 64'(bus.EST_ACK), 64'd0);
      if (mask != 2'b00) begin
         repeat (delay) @(posedge CLK);
         #1;
         bus.EST_DONE = bus.EST_DONE | mask;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.BUSY && n < 10000) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("wait_idle", 64'(bus.BUSY), 64'd0);
   endtask

   initial begin
      int rd0;
      bus.START = 1'b0;
      bus.NUM_SAMPLES = '0;
      bus.SMP_DATA = '0;
      bus.SMP_VALID = 1'b0;
      bus.EST_DONE = '0;
      bus.RES_READY = 1'b1;

      // reset state
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      chk("rst_busy", 64'(bus.BUSY), 64'd0);
      chk("rst_valid", 64'(bus.RES_VALID), 64'd0);
      chk("rst_ack", 64'(bus.EST_ACK), 64'd0);
      chk("rst_smp_cnt", 64'(bus.SMP_CNT), 64'd0);
      chk("rst_run_done", 64'(bus.RUN_DONE), 64'd0);
      chk("rst_smp_ready", 64'(bus.SMP_READY), 64'd0);

      // clean run of 4, with an ignored START in the middle
      rd0 = run_done_cnt;
      start_run(4);
      do_sample(64'h0000_1000_0000_0001, 64'h0000_1100_0000_0002, 2'b11, 10, 0, 2'b11, 12);
      do_sample(64'hDEAD_BEEF_1234_5678, 64'hDEAD_BFEF_1234_5679, 2'b11, 10, 0, 2'b11, 12);
      bus.NUM_SAMPLES = 11'd1;
      bus.START = 1'b1;
      @(posedge CLK); #1;
      bus.START = 1'b0;
      do_sample(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_00FF_0000_0000, 2'b11, 10, 0, 2'b11, 12);
      do_sample(64'h0123_4567_89AB_CDEF, 64'h0123_4667_89AB_CDF0, 2'b11, 10, 0, 2'b11, 12);
      wait_idle();
      chk("clean_smp_cnt", 64'(bus.SMP_CNT), 64'd4);
      chk("clean_timeouts", 64'(bus.TIMEOUT_CNT), 64'd0);
      chk("clean_run_done", 64'(run_done_cnt - rd0), 64'd1);

      // partial done -> timeout, stale done -> timeout, last edge at HOLD-1 -> clean
      rd0 = run_done_cnt;
      start_run(3);
      do_sample(64'hA5A5_A5A5_5A5A_5A5A, 64'hA5A5_A6A5_5A5A_5A5B, 2'b01, 10, 0, 2'b01, LAT_TO);
      do_sample(64'h1111_1111_2222_2222, 64'h1111_1211_2222_2223, 2'b00, 0, 1, 2'b00, LAT_TO);
      do_sample(64'h7FFF_FF00_8000_0000, 64'h8000_0000_8000_0001, 2'b11, HOLD-1, 0, 2'b11, LAT_TO);
      wait_idle();
      chk("to_smp_cnt", 64'(bus.SMP_CNT), 64'd3);
      chk("to_timeouts", 64'(bus.TIMEOUT_CNT), 64'd2);
      chk("to_run_done", 64'(run_done_cnt - rd0), 64'd1);

      // backpressure
      start_run(2);
      bus.RES_READY = 1'b0;
      do_sample(64'h0000_0F00_0000_00FF, 64'h0000_1000_0000_0100, 2'b11, 10, 0, 2'b11, 12);
      for (int i = 0; i < 20 && !bus.RES_VALID; i++) begin
         @(posedge CLK); #1;
      end
      chk("bp_valid", 64'(bus.RES_VALID), 64'd1);
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         chk("bp_data", bus.RES_DATA, 64'h0000_1000_0000_0100);
         chk("bp_smp_ready", 64'(bus.SMP_READY), 64'd0);
         chk("bp_ack", 64'(bus.EST_ACK), 64'd3);
      end
      bus.RES_READY = 1'b1;
      @(posedge CLK); #1;
      chk("bp_fetch_ack", 64'(bus.EST_ACK), 64'd3);
      chk("bp_fetch_ready", 64'(bus.SMP_READY), 64'd1);
      chk("bp_fetch_valid", 64'(bus.RES_VALID), 64'd0);
      do_sample(64'hCAFE_0000_BEEF_0000, 64'hCAFE_0100_BEEF_0001, 2'b11, 5, 0, 2'b11, 7);
      wait_idle();
      chk("bp_smp_cnt", 64'(bus.SMP_CNT), 64'd2);

      // NUM_SAMPLES == 0
      rd0 = run_done_cnt;
      start_run(0);
      chk("zero_run_done", 64'(bus.RUN_DONE), 64'd1);
      chk("zero_smp_cnt", 64'(bus.SMP_CNT), 64'd0);
      @(posedge CLK); #1;
      chk("zero_run_done_end", 64'(bus.RUN_DONE), 64'd0);
      chk("zero_busy", 64'(bus.BUSY), 64'd0);
      chk("zero_pulses", 64'(run_done_cnt - rd0), 64'd1);

      // reset in the middle of WAIT
      start_run(2);
      do_sample(64'h0000_0000_0000_0033, 64'h0000_0100_0000_0034, 2'b00, 0, 0, 2'b00, LAT_TO);
      repeat (20) @(posedge CLK);
      #1;
      chk("mid_busy", 64'(bus.BUSY), 64'd1);
      rd0 = run_done_cnt;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      sb.delete();
      chk("mid_rst_busy", 64'(bus.BUSY), 64'd0);
      chk("mid_rst_valid", 64'(bus.RES_VALID), 64'd0);
      chk("mid_rst_ack", 64'(bus.EST_ACK), 64'd0);
      chk("mid_rst_smp_cnt", 64'(bus.SMP_CNT), 64'd0);
      chk("mid_rst_smp_ready", 64'(bus.SMP_READY), 64'd0);
      repeat (3) @(posedge CLK);
      #1;
      chk("mid_rst_no_done", 64'(run_done_cnt - rd0), 64'd0);

      chk("sb_leftover", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
